// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for the five-stage pipeline: load-use, branch flush,
// fetch wait and multi-cycle data-memory handshake with timeout, plus a stall counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    input  logic [4:0]           rd_ex,
    input  logic                 mem_read_ex,
    input  logic                 branch_taken_ex,
    input  logic                 mem_read_mem,
    input  logic                 mem_write_mem,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 dmem_req,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_id,
    output logic                 stall_ex,
    output logic                 bubble_ex,
    output logic                 stall_mem,
    output logic                 bubble_mem,
    output logic                 stall_wb,
    output logic                 bubble_wb,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [WCW-1:0]       wait_cnt_reg, wait_cnt_next;
    logic                 mem_err_reg, mem_err_next;
    logic [CNT_WIDTH-1:0] stall_cycles_reg, stall_cycles_next;

    logic mem_acc;
    logic mem_wait;
    logic load_use;

    assign mem_acc  = mem_read_mem | mem_write_mem;
    assign mem_wait = ((state_reg == S_IDLE) & mem_acc & ~dmem_ready) |
                      ((state_reg == S_WAIT) & ~dmem_ready);
    assign load_use = mem_read_ex & (rd_ex != 5'd0) &
                      ((rd_ex == rs1_id) | (rd_ex == rs2_id));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            wait_cnt_reg     <= '0;
            mem_err_reg      <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            mem_err_reg      <= mem_err_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    // Next-state logic; dmem_ready wins over the timeout in the same cycle.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        case (state_reg)
            S_IDLE: begin
                if (mem_acc && !dmem_ready) begin
                    state_next    = S_WAIT;
                    wait_cnt_next = '0;
                end
            end
            S_WAIT: begin
                wait_cnt_next = wait_cnt_reg + WCW'(1);
                if (dmem_ready) begin
                    state_next = S_IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next   = S_ERR;
                    mem_err_next = 1'b1;
                end
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (stall_if && (stall_cycles_reg != {CNT_WIDTH{1'b1}})) begin
            stall_cycles_next = stall_cycles_reg + CNT_WIDTH'(1);
        end
    end

    // Pipeline control, highest priority first.
    always_comb begin
        dmem_req   = 1'b0;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        bubble_id  = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        stall_mem  = 1'b0;
        bubble_mem = 1'b0;
        stall_wb   = 1'b0;
        bubble_wb  = 1'b0;
        if (!rst_n) begin
            bubble_id  = 1'b1;
            bubble_ex  = 1'b1;
            bubble_mem = 1'b1;
            bubble_wb  = 1'b1;
        end else if (state_reg == S_ERR) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            bubble_wb = 1'b1;
        end else begin
            dmem_req = (state_reg == S_WAIT) | mem_acc;
            if (mem_wait) begin
                // Freeze everything upstream of WB; WB gets a bubble so it never retires twice.
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_ex  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (branch_taken_ex) begin
                bubble_id = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (!imem_ready) begin
                stall_if  = 1'b1;
                bubble_id = 1'b1;
            end
        end
    end

    assign mem_err      = mem_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by random
// stimulus, expected responses from a behavioural model queued for a separate monitor.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [4:0]    rs1_id, rs2_id, rd_ex;
    logic          mem_read_ex, branch_taken_ex, mem_read_mem, mem_write_mem;
    logic          imem_ready, dmem_ready;
    logic          dmem_req, stall_if, stall_id, bubble_id, stall_ex, bubble_ex;
    logic          stall_mem, bubble_mem, stall_wb, bubble_wb, mem_err;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken_ex(branch_taken_ex),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .stall_if(stall_if),
        .stall_id(stall_id), .bubble_id(bubble_id),
        .stall_ex(stall_ex), .bubble_ex(bubble_ex),
        .stall_mem(stall_mem), .bubble_mem(bubble_mem),
        .stall_wb(stall_wb), .bubble_wb(bubble_wb),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [9:0] ctl;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    // Model: a pending-access flag with the number of wait cycles already spent,
    // a sticky error flag and a plain integer stall count.
    bit m_pending;
    int m_waited;
    bit m_err;
    int m_cnt;

    // ctl order: req, s_if, s_id, b_id, s_ex, b_ex, s_mem, b_mem, s_wb, b_wb
    task automatic step(input bit r, input int rs1, input int rs2, input int rd,
                        input bit mre, input bit br, input bit mrm, input bit mwm,
                        input bit im, input bit dm);
        exp_t e;
        bit   acc, hold, lu;
        bit   req, s_if, s_id, b_id, s_ex, b_ex, s_mem, b_mem, s_wb, b_wb;
        rst_n = r; rs1_id = 5'(rs1); rs2_id = 5'(rs2); rd_ex = 5'(rd);
        mem_read_ex = mre; branch_taken_ex = br; mem_read_mem = mrm;
        mem_write_mem = mwm; imem_ready = im; dmem_ready = dm;

        acc = mrm | mwm;
        lu  = mre && rd != 0 && (rd == rs1 || rd == rs2);
        {req, s_if, s_id, b_id, s_ex, b_ex, s_mem, b_mem, s_wb, b_wb} = '0;
        if (!r) begin
            {b_id, b_ex, b_mem, b_wb} = 4'b1111;
        end else if (m_err) begin
            {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
        end else begin
            req  = m_pending | acc;
            hold = (m_pending | acc) & !dm;
            if (hold)             {s_if, s_id, s_ex, s_mem, b_wb} = 5'b11111;
            else if (br)          {b_id, b_ex} = 2'b11;
            else if (lu)          {s_if, s_id, b_ex} = 3'b111;
            else if (!im)         {s_if, b_id} = 2'b11;
        end
        e.idx = txn;
        e.ctl = {req, s_if, s_id, b_id, s_ex, b_ex, s_mem, b_mem, s_wb, b_wb};
        e.err = m_err;
        e.cnt = m_cnt;
        q.push_back(e);
        txn++;

        if (!r) begin
            m_pending = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (s_if) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (!m_err) begin
                if (m_pending) begin
                    if (dm) begin
                        m_pending = 0;
                    end else if (m_waited + 1 == TMO) begin
                        m_pending = 0;
                        m_err = 1;
                    end else begin
                        m_waited++;
                    end
                end else if (acc && !dm) begin
                    m_pending = 1;
                    m_waited  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a response, compare with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({dmem_req, stall_if, stall_id, bubble_id, stall_ex, bubble_ex,
                     stall_mem, bubble_mem, stall_wb, bubble_wb} !== e.ctl) begin
                    errors++;
                    $display("FAIL txn %0d ctl: got %b want %b", e.idx,
                             {dmem_req, stall_if, stall_id, bubble_id, stall_ex, bubble_ex,
                              stall_mem, bubble_mem, stall_wb, bubble_wb}, e.ctl);
                end
                checks++;
                if (mem_err !== e.err) begin
                    errors++;
                    $display("FAIL txn %0d mem_err: got %b want %b", e.idx, mem_err, e.err);
                end
                checks++;
                if (stall_cycles !== CW'(e.cnt)) begin
                    errors++;
                    $display("FAIL txn %0d stall_cycles: got %0d want %0d", e.idx,
                             stall_cycles, e.cnt);
                end
                $display("txn %0d ctl=%b mem_err=%b stall_cycles=%0d", e.idx,
                         e.ctl, e.err, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rs1_id = '0; rs2_id = '0; rd_ex = '0;
        mem_read_ex = 0; branch_taken_ex = 0; mem_read_mem = 0; mem_write_mem = 0;
        imem_ready = 1; dmem_ready = 1;
        m_pending = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and a checked reset cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Load-use, then free
        step(1, 0, 5, 5, 1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // rd_ex == 0 never stalls
        step(1, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        // Branch overrides load-use
        step(1, 0, 5, 5, 1, 1, 0, 0, 1, 1);
        // Three-cycle memory wait
        repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Single-cycle store
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Timeout into ERR, late ready ignored, reset recovers
        repeat (6) step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Fetch wait and counter saturation
        repeat (10) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 4,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
